bip_cpu_core: RTL and testbench
===============================

# bip_cpu_core

Parametrised accumulator CPU core, successor to the fixed 16-bit BIP I top: program counter, decoder, accumulator datapath and memory sequencing in one block. Adds generic data/address widths, a data-memory ready handshake with stall, a HALT state with status output, and optional branch instructions. It sits between the program ROM and the data RAM in the practice-board top level.

## Interface
- DATA_W, 16, accumulator and data-bus width (≥ ADDR_W).
- ADDR_W, 11, instruction and data address width; also operand field width.
- INS_W, 5+ADDR_W, instruction width: opcode [INS_W-1:ADDR_W], operand [ADDR_W-1:0]. Derived; not overridden.

- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InsAddr  out  ADDR_W  program memory address (= PC).
- Instruction  in  INS_W  instruction word from asynchronous program memory.
- Rd  out  1  data memory read strobe.
- Wr  out  1  data memory write strobe.
- DataAddr  out  ADDR_W  data memory address (= operand field).
- In_Data  out  DATA_W  write data to RAM (= accumulator).
- Out_Data  in  DATA_W  read data from RAM.
- DataReady  in  1  RAM completes the current Rd/Wr access this cycle.
- Halted  out  1  core is in HALT.
- AccOut  out  DATA_W  accumulator value, for observation.

## Operation
- States: RUN, WAIT, HALT. Reset: state RUN, PC=0, Acc=0, Halted=0; Rd=Wr=0 while Reset low.
- Opcodes: 00000 HLT; 00001 STO (RAM[op]←Acc); 00010 LD (Acc←RAM[op]); 00011 LDI (Acc←SE(op)); 00100 ADD (Acc←Acc+RAM[op]); 00101 ADDI (Acc←Acc+SE(op)); 00110 SUB (Acc←Acc−RAM[op]); 00111 SUBI (Acc←Acc−SE(op)); 01000 BEQ (PC←op if Acc==0); 01001 BNE (PC←op if Acc!=0); 01010 JMP (PC←op). All other opcodes: NOP.
- SE(op): operand sign-extended from ADDR_W to DATA_W. Arithmetic wraps modulo 2^DATA_W; no flags stored.
- Decode is combinational from Instruction; Rd asserted for LD/ADD/SUB, Wr for STO, in RUN and WAIT only. DataAddr always equals operand field.
- RUN, non-memory op: executes in one cycle; PC←PC+1 (or branch target). HLT: state→HALT, PC not advanced.
- RUN, memory op with DataReady=1: completes that cycle (Acc updated from Out_Data for reads), PC+1, stay RUN.
- RUN, memory op with DataReady=0: state→WAIT; PC, Acc held; Rd/Wr and DataAddr held.
- WAIT: stays until DataReady=1, then completes as above and returns to RUN.
- HALT: Rd=Wr=0, PC and Acc frozen, Halted=1; left only by Reset.
- PC wraps from 2^ADDR_W−1 to 0.
- Reset low in any state, including WAIT mid-access: immediate return to reset values; the pending access is abandoned.

## Timing
- One instruction per cycle when DataReady is high; each DataReady-low cycle adds one stall cycle.
- First fetch at InsAddr=0 in the first cycle after Reset deasserts.
- Acc and PC update on the edge ending the completing cycle; AccOut reflects the new value one cycle after issue.
- In_Data for STO is the Acc value before the STO edge.
- Halted rises on the edge that executes HLT.

## Configuration
- BIP_BRANCH_EN defined: BEQ/BNE/JMP are decoded as specified.
- Undefined: opcodes 01000–01010 are NOPs (PC+1), and the branch logic is not built.

## Test plan
- LDI 5; ADDI 3; STO 10; HLT with DataReady=1 → RAM[10]=8, Halted=1 after 4 cycles, PC stays 3.
- LDI 0x7FF (ADDR_W=11) → Acc=0xFFFF (sign-extended); SUBI 1 → Acc=0xFFFE; ADDI 2 → Acc=0x0000 (wrap).
- LD 4 with DataReady low for 3 cycles, RAM[4]=0x1234 → Rd high 4 cycles, PC held, Acc=0x1234 on the 4th edge.
- With BIP_BRANCH_EN: LDI 0; BEQ 7 → PC=7; LDI 1; BNE 2 → PC=2; JMP 0x7FF; NOP → PC wraps to 0. Without the macro, the same opcodes only step the PC.
- Reset asserted during WAIT of STO → Wr=0 immediately; after release PC=0, Acc=0, state RUN.
- Undefined opcode 11111 → Acc unchanged, PC+1, Rd=Wr=0.

Source files
------------

// File: rtl/bip_cpu_core_if.sv
// Program/data memory bus of the BIP accumulator core.
// The core drives the master side; memories and observers use the slave side.
interface bip_cpu_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    localparam int INS_W = 5 + ADDR_W;

    logic [ADDR_W-1:0] InsAddr;
    logic [INS_W-1:0]  Instruction;
    logic              Rd;
    logic              Wr;
    logic [ADDR_W-1:0] DataAddr;
    logic [DATA_W-1:0] In_Data;
    logic [DATA_W-1:0] Out_Data;
    logic              DataReady;
    logic              Halted;
    logic [DATA_W-1:0] AccOut;

    modport master (
        output InsAddr, Rd, Wr, DataAddr, In_Data, Halted, AccOut,
        input  Instruction, Out_Data, DataReady
    );

    modport slave (
        input  InsAddr, Rd, Wr, DataAddr, In_Data, Halted, AccOut,
        output Instruction, Out_Data, DataReady
    );
endinterface

// File: rtl/bip_cpu_core.sv
// BIP accumulator CPU core: PC, decoder, accumulator and RAM stall sequencing.
// Define BIP_BRANCH_EN to build the BEQ/BNE/JMP branch logic.
module bip_cpu_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input logic            Clock,
    input logic            Reset,
    bip_cpu_core_if.master bus
);
    localparam int INS_W = 5 + ADDR_W;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, operand;
    logic [DATA_W-1:0] acc, acc_nxt, imm;
    logic [4:0]        opcode;

    logic op_hlt, op_sto, op_ld, op_ldi;
    logic op_add, op_addi, op_sub, op_subi;
`ifdef BIP_BRANCH_EN
    logic op_beq, op_bne, op_jmp;
`endif
    logic mem_rd, mem_op, active;

    assign opcode  = bus.Instruction[INS_W-1:ADDR_W];
    assign operand = bus.Instruction[ADDR_W-1:0];
    assign imm     = DATA_W'($signed(operand));
    assign pc_inc  = pc + ADDR_W'(1);

    always_comb begin
        op_hlt  = 1'b0;
        op_sto  = 1'b0;
        op_ld   = 1'b0;
        op_ldi  = 1'b0;
        op_add  = 1'b0;
        op_addi = 1'b0;
        op_sub  = 1'b0;
        op_subi = 1'b0;
`ifdef BIP_BRANCH_EN
        op_beq  = 1'b0;
        op_bne  = 1'b0;
        op_jmp  = 1'b0;
`endif
        unique case (opcode)
            5'b00000: op_hlt  = 1'b1;
            5'b00001: op_sto  = 1'b1;
            5'b00010: op_ld   = 1'b1;
            5'b00011: op_ldi  = 1'b1;
            5'b00100: op_add  = 1'b1;
            5'b00101: op_addi = 1'b1;
            5'b00110: op_sub  = 1'b1;
            5'b00111: op_subi = 1'b1;
`ifdef BIP_BRANCH_EN
            5'b01000: op_beq  = 1'b1;
            5'b01001: op_bne  = 1'b1;
            5'b01010: op_jmp  = 1'b1;
`endif
            default: ;
        endcase
    end

    assign mem_rd = op_ld | op_add | op_sub;
    assign mem_op = mem_rd | op_sto;
    assign active = (state != ST_HALT);

    // Strobes are gated by Reset so a pending access drops the moment reset hits
    assign bus.Rd       = Reset & active & mem_rd;
    assign bus.Wr       = Reset & active & op_sto;
    assign bus.InsAddr  = pc;
    assign bus.DataAddr = operand;
    assign bus.In_Data  = acc;
    assign bus.AccOut   = acc;
    assign bus.Halted   = (state == ST_HALT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        acc_nxt   = acc;
        unique case (state)
            ST_RUN, ST_WAIT: begin
                if (mem_op && !bus.DataReady) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_RUN;
                    pc_nxt    = pc_inc;
                    unique case (1'b1)
                        op_hlt: begin
                            state_nxt = ST_HALT;
                            pc_nxt    = pc;
                        end
                        op_ld:   acc_nxt = bus.Out_Data;
                        op_ldi:  acc_nxt = imm;
                        op_add:  acc_nxt = acc + bus.Out_Data;
                        op_addi: acc_nxt = acc + imm;
                        op_sub:  acc_nxt = acc - bus.Out_Data;
                        op_subi: acc_nxt = acc - imm;
`ifdef BIP_BRANCH_EN
                        op_beq: if (acc == '0) pc_nxt = operand;
                        op_bne: if (acc != '0) pc_nxt = operand;
                        op_jmp: pc_nxt = operand;
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_RUN;
            pc    <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            acc   <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_bip_cpu_core.sv
// Self-checking bench for bip_cpu_core: directed scenarios plus random programs
// checked against an instruction-level model of the BIP machine.
module tb_bip_cpu_core;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int INS_W  = 5 + ADDR_W;
    localparam int MEM_N  = 1 << ADDR_W;

    localparam logic [4:0] HLT  = 5'b00000;
    localparam logic [4:0] STO  = 5'b00001;
    localparam logic [4:0] LD   = 5'b00010;
    localparam logic [4:0] LDI  = 5'b00011;
    localparam logic [4:0] ADD  = 5'b00100;
    localparam logic [4:0] ADDI = 5'b00101;
    localparam logic [4:0] SUB  = 5'b00110;
    localparam logic [4:0] SUBI = 5'b00111;
    localparam logic [4:0] BEQ  = 5'b01000;
    localparam logic [4:0] BNE  = 5'b01001;
    localparam logic [4:0] JMP  = 5'b01010;
    localparam logic [4:0] NOP  = 5'b11111;

    logic Clock;
    logic Reset;

    bip_cpu_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    bip_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [INS_W-1:0]  rom   [MEM_N];
    logic [DATA_W-1:0] ram   [MEM_N];
    logic [DATA_W-1:0] m_ram [MEM_N];

    logic [ADDR_W-1:0] m_pc;
    logic [DATA_W-1:0] m_acc;
    logic              m_halt;

    int vectors;
    int miscompares;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign bus.Instruction = rom[bus.InsAddr];
    assign bus.Out_Data    = ram[bus.DataAddr];

    always @(posedge Clock)
        if (Reset && bus.Wr && bus.DataReady)
            ram[bus.DataAddr] <= bus.In_Data;

    function automatic logic [INS_W-1:0] mk(input logic [4:0] op,
                                            input logic [ADDR_W-1:0] a);
        return {op, a};
    endfunction

    function automatic logic [4:0] m_op();
        logic [INS_W-1:0] w;
        w = rom[m_pc];
        return w[INS_W-1:ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] m_arg();
        logic [INS_W-1:0] w;
        w = rom[m_pc];
        return w[ADDR_W-1:0];
    endfunction

    function automatic logic exp_rd();
        logic [4:0] op;
        op = m_op();
        return !m_halt && (op == LD || op == ADD || op == SUB);
    endfunction

    function automatic logic exp_wr();
        return !m_halt && (m_op() == STO);
    endfunction

    // Architectural model: an instruction retires unless it touches RAM
    // while the memory is not ready
    task automatic model_step(input logic rdy);
        logic [4:0]        op;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] se;
        if (m_halt) return;
        op = m_op();
        a  = m_arg();
        se = DATA_W'($signed(a));
        if ((exp_rd() || exp_wr()) && !rdy) return;
        case (op)
            HLT: begin
                m_halt = 1'b1;
                return;
            end
            STO:  m_ram[a] = m_acc;
            LD:   m_acc = m_ram[a];
            LDI:  m_acc = se;
            ADD:  m_acc = m_acc + m_ram[a];
            ADDI: m_acc = m_acc + se;
            SUB:  m_acc = m_acc - m_ram[a];
            SUBI: m_acc = m_acc - se;
`ifdef BIP_BRANCH_EN
            BEQ: if (m_acc == 0) begin
                m_pc = a;
                return;
            end
            BNE: if (m_acc != 0) begin
                m_pc = a;
                return;
            end
            JMP: begin
                m_pc = a;
                return;
            end
`endif
            default: ;
        endcase
        m_pc = m_pc + 1'b1;
    endtask

    task automatic cycle(input logic rdy);
        bus.DataReady = rdy;
        @(posedge Clock);
        model_step(rdy);
        @(negedge Clock);
    endtask

    task automatic model_reset();
        m_pc   = '0;
        m_acc  = '0;
        m_halt = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        bus.DataReady = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < MEM_N; i++) rom[i] = mk(NOP, '0);
    endtask

    task automatic set_ram(input int a, input logic [DATA_W-1:0] d);
        ram[a]   = d;
        m_ram[a] = d;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = mk(LD, 11'd4);
        Reset = 1'b0;
        bus.DataReady = 1'b1;
        @(negedge Clock);
        vectors++;
        if (bus.InsAddr !== 0 || bus.AccOut !== 0 || bus.Halted !== 0) begin
            miscompares++;
            $display("FAIL reset_state pc=%h acc=%h halted=%b want 0/0/0",
                     bus.InsAddr, bus.AccOut, bus.Halted);
        end
        vectors++;
        if (bus.Rd !== 1'b0 || bus.Wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes rd=%b wr=%b want 0/0", bus.Rd, bus.Wr);
        end
        Reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (bus.Rd !== 1'b1 || bus.InsAddr !== 0) begin
            miscompares++;
            $display("FAIL first_fetch rd=%b pc=%h want 1/000", bus.Rd, bus.InsAddr);
        end
        @(negedge Clock);
    endtask

    task automatic test_program();
        clear_rom();
        rom[0] = mk(LDI, 11'd5);
        rom[1] = mk(ADDI, 11'd3);
        rom[2] = mk(STO, 11'd10);
        rom[3] = mk(HLT, 11'd0);
        set_ram(10, '0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1);
        vectors++;
        if (ram[10] !== 16'd8) begin
            miscompares++;
            $display("FAIL prog_store ram10=%h want 0008", ram[10]);
        end
        vectors++;
        if (bus.Halted !== 1'b1 || bus.InsAddr !== 11'd3) begin
            miscompares++;
            $display("FAIL prog_halt halted=%b pc=%h want 1/003",
                     bus.Halted, bus.InsAddr);
        end
        cycle(1'b1);
        cycle(1'b0);
        vectors++;
        if (bus.InsAddr !== 11'd3 || bus.AccOut !== 16'd8 ||
            bus.Rd !== 1'b0 || bus.Wr !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_frozen pc=%h acc=%h rd=%b wr=%b want 003/0008/0/0",
                     bus.InsAddr, bus.AccOut, bus.Rd, bus.Wr);
        end
    endtask

    task automatic test_sign_wrap();
        logic [DATA_W-1:0] want [3];
        want[0] = 16'hFFFF;
        want[1] = 16'hFFFE;
        want[2] = 16'h0000;
        clear_rom();
        rom[0] = mk(LDI, 11'h7FF);
        rom[1] = mk(SUBI, 11'd1);
        rom[2] = mk(ADDI, 11'd2);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            vectors++;
            if (bus.AccOut !== want[i]) begin
                miscompares++;
                $display("FAIL sign_wrap step%0d acc=%h want %h",
                         i, bus.AccOut, want[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic rdy;
        clear_rom();
        rom[0] = mk(LD, 11'd4);
        set_ram(4, 16'h1234);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rdy = (i == 3);
            bus.DataReady = rdy;
            #1;
            vectors++;
            if (bus.Rd !== 1'b1 || bus.InsAddr !== 0 || bus.AccOut !== 0 ||
                bus.DataAddr !== 11'd4) begin
                miscompares++;
                $display("FAIL stall_hold c%0d rd=%b pc=%h acc=%h addr=%h want 1/000/0000/004",
                         i, bus.Rd, bus.InsAddr, bus.AccOut, bus.DataAddr);
            end
            cycle(rdy);
        end
        vectors++;
        if (bus.AccOut !== 16'h1234 || bus.InsAddr !== 11'd1) begin
            miscompares++;
            $display("FAIL stall_done acc=%h pc=%h want 1234/001",
                     bus.AccOut, bus.InsAddr);
        end
    endtask

    task automatic test_branch();
        logic [ADDR_W-1:0] want [6];
`ifdef BIP_BRANCH_EN
        want[0] = 11'd1;
        want[1] = 11'd7;
        want[2] = 11'd8;
        want[3] = 11'd2;
        want[4] = 11'h7FF;
        want[5] = 11'd0;
`else
        for (int i = 0; i < 6; i++) want[i] = ADDR_W'(i + 1);
`endif
        clear_rom();
        rom[0]     = mk(LDI, 11'd0);
        rom[1]     = mk(BEQ, 11'd7);
        rom[7]     = mk(LDI, 11'd1);
        rom[8]     = mk(BNE, 11'd2);
        rom[2]     = mk(JMP, 11'h7FF);
        rom[11'h7FF] = mk(NOP, 11'd0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1);
            vectors++;
            if (bus.InsAddr !== want[i]) begin
                miscompares++;
                $display("FAIL branch_pc step%0d pc=%h want %h",
                         i, bus.InsAddr, want[i]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        clear_rom();
        rom[0] = mk(LDI, 11'd9);
        rom[1] = mk(STO, 11'd5);
        set_ram(5, 16'hAAAA);
        do_reset();
        cycle(1'b1);
        cycle(1'b0);
        vectors++;
        if (bus.Wr !== 1'b1 || bus.InsAddr !== 11'd1) begin
            miscompares++;
            $display("FAIL wait_entry wr=%b pc=%h want 1/001", bus.Wr, bus.InsAddr);
        end
        Reset = 1'b0;
        #1;
        vectors++;
        if (bus.Wr !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_reset_wr wr=%b want 0", bus.Wr);
        end
        @(negedge Clock);
        vectors++;
        if (bus.InsAddr !== 0 || bus.AccOut !== 0 || ram[5] !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL wait_reset_state pc=%h acc=%h ram5=%h want 000/0000/aaaa",
                     bus.InsAddr, bus.AccOut, ram[5]);
        end
        Reset = 1'b1;
        model_reset();
        cycle(1'b1);
        vectors++;
        if (bus.InsAddr !== 11'd1 || bus.AccOut !== 16'd9 || bus.Halted !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_reset_run pc=%h acc=%h halted=%b want 001/0009/0",
                     bus.InsAddr, bus.AccOut, bus.Halted);
        end
    endtask

    task automatic test_undefined();
        clear_rom();
        rom[0] = mk(LDI, 11'h55);
        rom[1] = mk(5'b11111, 11'h123);
        do_reset();
        cycle(1'b1);
        #1;
        vectors++;
        if (bus.Rd !== 1'b0 || bus.Wr !== 1'b0) begin
            miscompares++;
            $display("FAIL undef_strobes rd=%b wr=%b want 0/0", bus.Rd, bus.Wr);
        end
        cycle(1'b1);
        vectors++;
        if (bus.AccOut !== 16'h0055 || bus.InsAddr !== 11'd2) begin
            miscompares++;
            $display("FAIL undef_exec acc=%h pc=%h want 0055/002",
                     bus.AccOut, bus.InsAddr);
        end
    endtask

    task automatic test_random();
        logic [4:0]        op;
        logic [ADDR_W-1:0] a;
        logic              rdy;
        int                bad;
        for (int i = 0; i < MEM_N; i++) begin
            op = ($urandom_range(0, 99) == 0) ? HLT : 5'($urandom_range(1, 31));
            a  = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 15))
                                             : 11'($urandom);
            rom[i] = mk(op, a);
            set_ram(i, 16'($urandom));
        end
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            bus.DataReady = rdy;
            #1;
            vectors++;
            if (bus.InsAddr !== m_pc || bus.AccOut !== m_acc ||
                bus.Halted !== m_halt) begin
                miscompares++;
                $display("FAIL rand_state c%0d pc=%h acc=%h h=%b want %h/%h/%b",
                         c, bus.InsAddr, bus.AccOut, bus.Halted, m_pc, m_acc, m_halt);
            end
            vectors++;
            if (bus.Rd !== exp_rd() || bus.Wr !== exp_wr() ||
                bus.DataAddr !== m_arg()) begin
                miscompares++;
                $display("FAIL rand_bus c%0d rd=%b wr=%b addr=%h want %b/%b/%h",
                         c, bus.Rd, bus.Wr, bus.DataAddr, exp_rd(), exp_wr(), m_arg());
            end
            cycle(rdy);
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
        end
        bad = 0;
        for (int i = 0; i < MEM_N; i++) if (ram[i] !== m_ram[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rand_ram words_differing=%0d want 0", bad);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset = 1'b0;
        bus.DataReady = 1'b1;
        model_reset();
        for (int i = 0; i < MEM_N; i++) set_ram(i, '0);
        test_reset();
        test_program();
        test_sign_wrap();
        test_stall();
        test_branch();
        test_reset_in_wait();
        test_undefined();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
